shift_ser: RTL and testbench

Parallel-in, serial-out transmitter for the bit-serial data link. It accepts NDATA-bit words over a valid/ready handshake into a one-word holding buffer and shifts each word out MSB-first, one bit per active-low `ena` strobe. Its shift timing matches the link's serial-in, parallel-out receiver: when both blocks see the same `ena`, the receiver's parallel output equals the transmitted word once a frame completes. Back-to-back words go out with no idle bit between frames.

---
 rtl/ser_link_pkg.sv | 17 +
 rtl/word_buf.sv | 46 ++++
 rtl/shift_ser.sv | 109 ++++++++++
 tb/tb_shift_ser.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ser_link_pkg.sv
// Shared definitions for the bit-serial data link (transmitter and receiver).
// Holds the default word width, the FSM state type and the counter-width helper.
package ser_link_pkg;

  localparam int unsigned NDataDefault = 128;

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } state_e;

  // The counter holds values 0..n, so it needs one more code than n.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/word_buf.sv
// One-entry valid/ready holding register.
// A drain and a write never happen in the same cycle because ready is low while full.
module word_buf
  import ser_link_pkg::*;
#(
  parameter int unsigned Width = NDataDefault
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] wr_data_i,
  input  logic             wr_valid_i,
  output logic             wr_ready_o,
  input  logic             drain_i,
  output logic [Width-1:0] data_o,
  output logic             full_o
);

  logic [Width-1:0] data_q, data_d;
  logic             full_q, full_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (drain_i) begin
      full_d = 1'b0;
    end else if (wr_valid_i && !full_q) begin
      data_d = wr_data_i;
      full_d = 1'b1;
    end
  end

  assign wr_ready_o = !full_q;
  assign data_o     = data_q;
  assign full_o     = full_q;

endmodule

// File: rtl/shift_ser.sv
// Parallel-in, serial-out transmitter: buffers one word and shifts it out MSB-first,
// one bit per active-low ena strobe, reloading back-to-back with no idle bit.
module shift_ser
  import ser_link_pkg::*;
#(
  parameter int unsigned NDATA = NDataDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NDATA-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             ena,
  output logic             dout,
  output logic             dout_valid,
  output logic             frame_start,
  output logic             frame_done
);

  localparam int unsigned NCNT = cnt_width(NDATA);

  state_e           state_q, state_d;
  logic [NDATA-1:0] sreg_q, sreg_d;
  logic [NCNT-1:0]  cnt_q, cnt_d;
  logic             fs_q, fs_d;
  logic             fd_q, fd_d;
  logic [NDATA-1:0] buf_data;
  logic             buf_full;
  logic             drain;

  word_buf #(
    .Width(NDATA)
  ) u_word_buf (
    .clk_i     (clk),
    .rst_ni    (rst),
    .wr_data_i (din),
    .wr_valid_i(din_valid),
    .wr_ready_o(din_ready),
    .drain_i   (drain),
    .data_o    (buf_data),
    .full_o    (buf_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      sreg_q  <= '0;
      cnt_q   <= '0;
      fs_q    <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      fs_q    <= fs_d;
      fd_q    <= fd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    drain   = 1'b0;
    fs_d    = 1'b0;
    fd_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (buf_full) begin
          sreg_d  = buf_data;
          cnt_d   = NCNT'(NDATA);
          drain   = 1'b1;
          fs_d    = 1'b1;
          state_d = StShift;
        end
      end
      StShift: begin
        if (!ena) begin
          if (cnt_q > NCNT'(1)) begin
            sreg_d = {sreg_q[NDATA-2:0], 1'b0};
            cnt_d  = cnt_q - NCNT'(1);
          end else begin
            // Last bit consumed: chain straight into the buffered word if present.
            fd_d = 1'b1;
            if (buf_full) begin
              sreg_d = buf_data;
              cnt_d  = NCNT'(NDATA);
              drain  = 1'b1;
              fs_d   = 1'b1;
            end else begin
              sreg_d  = '0;
              cnt_d   = '0;
              state_d = StIdle;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    dout_valid  = (state_q == StShift);
    dout        = (state_q == StShift) ? sreg_q[NDATA-1] : 1'b0;
    frame_start = fs_q;
    frame_done  = fd_q;
  end

endmodule

// File: tb/tb_shift_ser.sv
// Bench for shift_ser: an 8-bit instance checked against a bit scoreboard and a
// 128-bit instance looped back into a behavioural receiver sharing its ena.
module tb_shift_ser;

  typedef struct {
    int fs_first;
    int nfs;
    int fd_first;
    int fd_last;
    int nfd;
    int nvalid;
    int v_first;
    int v_last;
    int coinc;
    int coinc_pos;
    int acc2_pos;
    int ready_low;
    int holds;
    int hold_viol;
  } stats_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;

  logic [7:0]   din8 = '0;
  logic         din_valid8 = 1'b0;
  logic         din_ready8;
  logic         ena8 = 1'b1;
  logic         dout8, dv8, fs8, fd8;

  logic [127:0] din128 = '0;
  logic         din_valid128 = 1'b0;
  logic         din_ready128;
  logic         ena128 = 1'b1;
  logic         dout128, dv128, fs128, fd128;

  logic [127:0] rx_q;
  logic         exp_q[$];
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  shift_ser #(
    .NDATA(8)
  ) dut8 (
    .clk        (clk),
    .rst        (rst),
    .din        (din8),
    .din_valid  (din_valid8),
    .din_ready  (din_ready8),
    .ena        (ena8),
    .dout       (dout8),
    .dout_valid (dv8),
    .frame_start(fs8),
    .frame_done (fd8)
  );

  shift_ser #(
    .NDATA(128)
  ) dut128 (
    .clk        (clk),
    .rst        (rst),
    .din        (din128),
    .din_valid  (din_valid128),
    .din_ready  (din_ready128),
    .ena        (ena128),
    .dout       (dout128),
    .dout_valid (dv128),
    .frame_start(fs128),
    .frame_done (fd128)
  );

  // Receiver model: samples the pre-shift bit on the same strobe edge.
  always @(posedge clk or negedge rst) begin
    if (!rst) rx_q <= '0;
    else if (dv128 && !ena128) rx_q <= {rx_q[126:0], dout128};
  end

  // Scoreboard: every bit about to be consumed must match the next expected bit.
  always @(negedge clk) begin : sb
    logic e;
    if (rst && dv8 && !ena8) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_extra_bit: got dout=%0b with no bit expected", dout8);
      end else begin
        e = exp_q.pop_front();
        if (dout8 !== e) begin
          errors++;
          $display("FAIL sb_bit: got dout=%0b, required %0b", dout8, e);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic push_word8(input logic [7:0] w);
    for (int b = 7; b >= 0; b--) exp_q.push_back(w[b]);
  endtask

  function automatic logic ena_for(input int i, input int stride);
    return (stride <= 1) ? 1'b0 : ((i % stride) != 1);
  endfunction

  // Drives one or two words into dut8 with a given strobe pattern and records timing.
  task automatic run_link(input logic [7:0] w0, input logic [7:0] w1, input bit two,
                          input int stride, input int ncyc, output stats_t s);
    bit   acc;
    int   nacc;
    logic prev_dv, prev_ena, prev_dout;
    s = '{fs_first: -1, fd_first: -1, fd_last: -1, v_first: -1, v_last: -1,
          coinc_pos: -1, acc2_pos: -1, default: 0};
    nacc = 0;
    prev_dv = 1'b0;
    prev_ena = 1'b0;
    prev_dout = 1'b0;
    @(posedge clk);
    #1;
    din8 = w0;
    din_valid8 = 1'b1;
    ena8 = ena_for(0, stride);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      acc = din_valid8 && din_ready8;
      if (acc) begin
        push_word8(din8);
        nacc++;
        if (nacc == 2) s.acc2_pos = i;
      end
      if (din_valid8 && !din_ready8) s.ready_low++;
      if (fs8) begin
        if (s.fs_first < 0) s.fs_first = i;
        s.nfs++;
      end
      if (fd8) begin
        if (s.fd_first < 0) s.fd_first = i;
        s.fd_last = i;
        s.nfd++;
      end
      if (fs8 && fd8) begin
        s.coinc++;
        s.coinc_pos = i;
      end
      if (dv8) begin
        if (s.v_first < 0) s.v_first = i;
        s.v_last = i;
        s.nvalid++;
      end
      if (dv8 && prev_dv && prev_ena) begin
        s.holds++;
        if (dout8 !== prev_dout) s.hold_viol++;
      end
      prev_dv = dv8;
      prev_ena = ena8;
      prev_dout = dout8;
      @(posedge clk);
      #1;
      if (acc) begin
        if (two && nacc == 1) din8 = w1;
        else din_valid8 = 1'b0;
      end
      ena8 = ena_for(i + 1, stride);
    end
    din_valid8 = 1'b0;
    ena8 = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (din_ready8 !== 1'b1) begin
      errors++;
      $display("FAIL reset_din_ready: got %0b, required 1", din_ready8);
    end
    checks++;
    if (dout8 !== 1'b0) begin errors++; $display("FAIL reset_dout: got %0b, required 0", dout8); end
    checks++;
    if (dv8 !== 1'b0) begin errors++; $display("FAIL reset_dout_valid: got %0b, required 0", dv8); end
    checks++;
    if ({fs8, fd8} !== 2'b00) begin
      errors++;
      $display("FAIL reset_pulses: got %b, required 00", {fs8, fd8});
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_single;
    stats_t s;
    run_link(8'hA5, 8'h00, 1'b0, 1, 14, s);
    checks++;
    if (s.fs_first !== 2) begin
      errors++;
      $display("FAIL single_fs_pos: got %0d, required 2", s.fs_first);
    end
    checks++;
    if (s.nfs !== 1) begin errors++; $display("FAIL single_fs_count: got %0d, required 1", s.nfs); end
    checks++;
    if (s.fd_first !== 10 || s.nfd !== 1) begin
      errors++;
      $display("FAIL single_fd: got pos %0d count %0d, required pos 10 count 1", s.fd_first, s.nfd);
    end
    checks++;
    if (s.nvalid !== 8 || s.v_first !== 2 || s.v_last !== 9) begin
      errors++;
      $display("FAIL single_valid: got %0d bits %0d..%0d, required 8 bits 2..9",
               s.nvalid, s.v_first, s.v_last);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL single_sb_left: got %0d bits pending, required 0", exp_q.size());
    end
    @(negedge clk);
    checks++;
    if ({dv8, dout8} !== 2'b00) begin
      errors++;
      $display("FAIL single_idle: got valid/dout %b, required 00", {dv8, dout8});
    end
  endtask

  task automatic test_back_to_back;
    stats_t s;
    run_link(8'hF0, 8'h0F, 1'b1, 1, 22, s);
    checks++;
    if (s.ready_low !== 1 || s.acc2_pos !== 2) begin
      errors++;
      $display("FAIL b2b_hold_accept: got ready_low %0d accept %0d, required 1 and 2",
               s.ready_low, s.acc2_pos);
    end
    checks++;
    if (s.nvalid !== 16 || s.v_first !== 2 || s.v_last !== 17) begin
      errors++;
      $display("FAIL b2b_valid: got %0d bits %0d..%0d, required 16 bits 2..17",
               s.nvalid, s.v_first, s.v_last);
    end
    checks++;
    if (s.coinc !== 1 || s.coinc_pos !== 10) begin
      errors++;
      $display("FAIL b2b_coincide: got %0d at %0d, required 1 at 10", s.coinc, s.coinc_pos);
    end
    checks++;
    if (s.nfs !== 2 || s.nfd !== 2 || s.fd_last !== 18) begin
      errors++;
      $display("FAIL b2b_pulses: got fs %0d fd %0d last fd %0d, required 2 2 18",
               s.nfs, s.nfd, s.fd_last);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL b2b_sb_left: got %0d bits pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_sparse;
    stats_t s;
    run_link(8'hC3, 8'h00, 1'b0, 3, 32, s);
    checks++;
    if (s.nvalid !== 24 || s.v_first !== 2 || s.v_last !== 25) begin
      errors++;
      $display("FAIL sparse_len: got %0d cycles %0d..%0d, required 24 cycles 2..25",
               s.nvalid, s.v_first, s.v_last);
    end
    checks++;
    if (s.holds !== 16 || s.hold_viol !== 0) begin
      errors++;
      $display("FAIL sparse_hold: got %0d holds %0d changed, required 16 holds 0 changed",
               s.holds, s.hold_viol);
    end
    checks++;
    if (s.fd_first !== 26 || s.nfd !== 1) begin
      errors++;
      $display("FAIL sparse_fd: got pos %0d count %0d, required pos 26 count 1", s.fd_first, s.nfd);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL sparse_sb_left: got %0d bits pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_frame;
    int fd_seen, dv_seen;
    @(posedge clk);
    #1;
    din8 = 8'hFF;
    din_valid8 = 1'b1;
    ena8 = 1'b0;
    push_word8(8'hFF);
    @(posedge clk);
    #1;
    din_valid8 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (dv8 !== 1'b1) begin errors++; $display("FAIL mid_in_frame: got valid %0b, required 1", dv8); end
    rst = 1'b0;
    #1;
    checks++;
    if ({dout8, dv8, din_ready8, fs8, fd8} !== 5'b00100) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %b, required 00100", {dout8, dv8, din_ready8, fs8, fd8});
    end
    exp_q.delete();
    fd_seen = 0;
    dv_seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (fd8) fd_seen++;
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (fd8) fd_seen++;
      if (dv8) dv_seen++;
    end
    ena8 = 1'b1;
    checks++;
    if (fd_seen !== 0) begin errors++; $display("FAIL mid_no_done: got %0d, required 0", fd_seen); end
    checks++;
    if (dv_seen !== 0) begin errors++; $display("FAIL mid_no_resume: got %0d, required 0", dv_seen); end
  endtask

  task automatic test_loopback;
    logic [127:0] word;
    bit acc, done;
    word = {$urandom(), $urandom(), $urandom(), $urandom()};
    done = 1'b0;
    @(posedge clk);
    #1;
    din128 = word;
    din_valid128 = 1'b1;
    ena128 = 1'($urandom_range(0, 1));
    for (int i = 0; i < 600 && !done; i++) begin
      @(negedge clk);
      acc = din_valid128 && din_ready128;
      if (fd128) done = 1'b1;
      @(posedge clk);
      #1;
      if (acc) din_valid128 = 1'b0;
      ena128 = 1'($urandom_range(0, 1));
    end
    ena128 = 1'b1;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL loop_done: got no frame_done within 600 cycles, required one");
    end else begin
      checks++;
      if (rx_q !== word) begin
        errors++;
        $display("FAIL loop_word: got %h, required %h", rx_q, word);
      end
    end
    @(negedge clk);
    checks++;
    if (dv128 !== 1'b0) begin errors++; $display("FAIL loop_idle: got %0b, required 0", dv128); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_sparse();
    test_reset_mid_frame();
    test_loopback();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
